// File: rtl/pipe_reg_pkg.sv
// Shared types for the elastic pipeline stage register.
// The encoding doubles as the entry count, so occupancy is read straight off the state.
package pipe_reg_pkg;

  typedef enum logic [1:0] {
    PR_EMPTY = 2'd0,
    PR_ONE   = 2'd1,
    PR_TWO   = 2'd2
  } pipe_reg_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, flush-to-NOP and an optional skid entry.
// With SKID_EN=1 upstream ready comes from a flop; with SKID_EN=0 it is combinational from dn_ready_i.
module pipe_stage_reg
  import pipe_reg_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE   = '0,
  parameter bit                    SKID_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  up_valid_i,
  input  logic [DATA_WIDTH-1:0] up_data_i,
  output logic                  up_ready_o,
  output logic                  dn_valid_o,
  output logic [DATA_WIDTH-1:0] dn_data_o,
  input  logic                  dn_ready_i,
  output logic [1:0]            occupancy_o
);

  pipe_reg_state_e       state_q;
  pipe_reg_state_e       state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic                  up_xfer;
  logic                  dn_xfer;

  assign up_xfer     = up_valid_i & up_ready_o;
  assign dn_xfer     = dn_valid_o & dn_ready_i;
  assign dn_valid_o  = (state_q != PR_EMPTY);
  assign dn_data_o   = main_q;
  assign occupancy_o = state_q;

  if (SKID_EN) begin : g_skid
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  ready_q;
    logic                  load_main_up;
    logic                  load_main_skid;
    logic                  load_skid;

    always_comb begin
      state_d        = state_q;
      load_main_up   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_i) begin
        state_d = PR_EMPTY;
      end else begin
        unique case (state_q)
          PR_EMPTY: begin
            if (up_xfer) begin
              state_d      = PR_ONE;
              load_main_up = 1'b1;
            end
          end
          PR_ONE: begin
            if (up_xfer && dn_xfer) begin
              load_main_up = 1'b1;
            end else if (up_xfer) begin
              state_d   = PR_TWO;
              load_skid = 1'b1;
            end else if (dn_xfer) begin
              state_d = PR_EMPTY;
            end
          end
          PR_TWO: begin
            if (dn_xfer) begin
              state_d        = PR_ONE;
              load_main_skid = 1'b1;
            end
          end
          default: state_d = PR_EMPTY;
        endcase
      end
    end

    // Ready is registered from next state so upstream never sees a comb path from downstream.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= PR_EMPTY;
        main_q  <= RESET_VALUE;
        skid_q  <= NOP_VALUE;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != PR_TWO);
        if (flush_i) begin
          main_q <= NOP_VALUE;
          skid_q <= NOP_VALUE;
        end else begin
          if (load_main_up) begin
            main_q <= up_data_i;
          end else if (load_main_skid) begin
            main_q <= skid_q;
          end
          if (load_skid) begin
            skid_q <= up_data_i;
          end
        end
      end
    end

    assign up_ready_o = ready_q;

  end else begin : g_noskid
    logic load_main_up;

    assign up_ready_o = (state_q == PR_EMPTY) | dn_ready_i;

    always_comb begin
      state_d      = state_q;
      load_main_up = 1'b0;
      if (flush_i) begin
        state_d = PR_EMPTY;
      end else if (up_xfer) begin
        state_d      = PR_ONE;
        load_main_up = 1'b1;
      end else if (dn_xfer) begin
        state_d = PR_EMPTY;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= PR_EMPTY;
        main_q  <= RESET_VALUE;
      end else begin
        state_q <= state_d;
        if (flush_i) begin
          main_q <= NOP_VALUE;
        end else if (load_main_up) begin
          main_q <= up_data_i;
        end
      end
    end
  end

  // A stalled payload must not change under the consumer unless the stage is being flushed.
  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (dn_valid_o && !dn_ready_i && !flush_i) |=> (dn_valid_o && $stable(dn_data_o)));

  a_two_not_ready : assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == PR_TWO && up_ready_o));

endmodule
